div_seq: RTL and testbench

Operand sequencer and result capture stage placed directly upstream of the repeated-subtraction divider (datapath plus control path). Accepts a dividend/divisor pair over a valid/ready handshake and serialises it onto the divider's shared 16-bit data bus with a start pulse. Waits for the divider's stop flag, then presents quotient and remainder downstream over a second valid/ready handshake. Intercepts divide-by-zero, which would never terminate a repeated-subtraction divider, and bounds every run with a watchdog.

---
 rtl/div_seq_if.sv | 29 ++
 rtl/div_seq.sv | 112 +++++++++++
 tb/tb_div_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Signal bundle between div_seq, its upstream producer, the divider it feeds
// and the downstream result consumer.
interface div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        div_start;
    logic [15:0] div_data;
    logic        div_stop;
    logic [15:0] div_q;
    logic [15:0] div_rem;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dz;
    logic        timeout;

    modport slave (
        input  in_valid, dividend, divisor, div_stop, div_q, div_rem, out_ready,
        output in_ready, div_start, div_data, out_valid, quotient, remainder, dz, timeout
    );

    modport master (
        output in_valid, dividend, divisor, div_stop, div_q, div_rem, out_ready,
        input  in_ready, div_start, div_data, out_valid, quotient, remainder, dz, timeout
    );
endinterface

// File: rtl/div_seq.sv
// Operand sequencer and result capture for a repeated-subtraction divider:
// serialises an operand pair onto the shared bus, waits for stop, returns the result.
module div_seq #(
    parameter int TIMEOUT_CYCLES = 70000,
    parameter int CNT_W          = 17
) (
    input  logic      clk,
    input  logic      rst_n,
    div_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        a_lat;
    logic [15:0]        b_lat;
    logic [15:0]        q_r;
    logic [15:0]        r_r;
    logic               dz_r;
    logic               to_r;
    logic [CNT_W-1:0]   cnt;
    logic               zero_div;
    logic               cnt_end;

    assign zero_div = (bus.divisor == 16'd0);
    assign cnt_end  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = zero_div ? DONE : START;
            START:   state_nxt = LOAD_A;
            LOAD_A:  state_nxt = LOAD_B;
            LOAD_B:  state_nxt = WAIT;
            // stop has priority over the watchdog when both land on the same edge
            WAIT:    if (bus.div_stop || cnt_end) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat <= 16'd0;
            b_lat <= 16'd0;
            q_r   <= 16'd0;
            r_r   <= 16'd0;
            dz_r  <= 1'b0;
            to_r  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_lat <= bus.dividend;
                        b_lat <= bus.divisor;
                        // divide-by-zero never reaches the divider: it would never stop
                        if (zero_div) begin
                            q_r  <= 16'hFFFF;
                            r_r  <= bus.dividend;
                            dz_r <= 1'b1;
                            to_r <= 1'b0;
                        end
                    end
                end
                LOAD_B: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.div_stop) begin
                        q_r  <= bus.div_q;
                        r_r  <= bus.div_rem;
                        dz_r <= 1'b0;
                        to_r <= 1'b0;
                    end else if (cnt_end) begin
                        q_r  <= 16'd0;
                        r_r  <= 16'd0;
                        dz_r <= 1'b0;
                        to_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.div_start = (state == START);
    assign bus.div_data  = (state == LOAD_A) ? a_lat :
                           (state == LOAD_B) ? b_lat : 16'd0;
    assign bus.out_valid = (state == DONE);
    assign bus.quotient  = q_r;
    assign bus.remainder = r_r;
    assign bus.dz        = dz_r;
    assign bus.timeout   = to_r;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a behavioural divider stub feeds the default instance,
// a second instance with a short watchdog exercises the timeout path.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_seq_if b0 ();
    div_seq_if b1 ();

    div_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    div_seq #(.TIMEOUT_CYCLES(16), .CNT_W(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    int total = 0;
    int bad   = 0;

    // Divider stub: samples the two operands after start, answers stub_lat cycles
    // later with a level stop that stays high until the next run has loaded.
    int          stub_lat  = 0;
    bit          stub_hold = 1'b0;
    int          sphase    = 0;
    int          scnt      = 0;
    logic [15:0] sa        = 16'd0;
    logic [15:0] sb        = 16'd1;
    logic        stub_stop = 1'b0;
    logic [15:0] stub_q    = 16'd0;
    logic [15:0] stub_r    = 16'd0;

    assign b0.div_stop = stub_stop;
    assign b0.div_q    = stub_q;
    assign b0.div_rem  = stub_r;

    always @(posedge clk) begin
        if (b0.div_start) begin
            sphase <= 1;
        end else begin
            case (sphase)
                1: begin
                    sa     <= b0.div_data;
                    sphase <= 2;
                end
                2: begin
                    sb   <= b0.div_data;
                    scnt <= 0;
                    if (stub_hold) begin
                        sphase <= 0;
                    end else begin
                        stub_stop <= 1'b0;
                        sphase    <= 3;
                    end
                end
                3: begin
                    if (scnt >= stub_lat) begin
                        stub_stop <= 1'b1;
                        stub_q    <= (sb == 16'd0) ? 16'hFFFF : sa / sb;
                        stub_r    <= (sb == 16'd0) ? sa : sa % sb;
                        sphase    <= 0;
                    end else begin
                        scnt <= scnt + 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Drives one pair into b0 starting at a negedge and collects what happens
    // until out_valid; cycle 1 is the cycle after the acceptance edge.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int budget,
                           output logic [15:0] q, output logic [15:0] r,
                           output logic fdz, output logic fto,
                           output int n_done, output int starts, output int start_cyc,
                           output logic [15:0] d2, output logic [15:0] d3,
                           output bit rdy_bad);
        int  k;
        int  n;
        bit  done;
        k = 0;
        while (b0.in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        b0.in_valid = 1'b1;
        b0.dividend = a;
        b0.divisor  = b;
        @(negedge clk);
        b0.in_valid = 1'b0;
        n = 1; done = 1'b0; starts = 0; start_cyc = -1;
        d2 = 16'd0; d3 = 16'd0; rdy_bad = 1'b0; n_done = -1;
        q = 16'd0; r = 16'd0; fdz = 1'b0; fto = 1'b0;
        while (!done && n <= budget) begin
            if (b0.div_start === 1'b1) begin
                starts++;
                if (start_cyc < 0) start_cyc = n;
            end
            if (n == 2) d2 = b0.div_data;
            if (n == 3) d3 = b0.div_data;
            if (b0.in_ready !== 1'b0) rdy_bad = 1'b1;
            if (b0.out_valid === 1'b1) begin
                done   = 1'b1;
                n_done = n;
                q      = b0.quotient;
                r      = b0.remainder;
                fdz    = b0.dz;
                fto    = b0.timeout;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    logic [15:0] g_q, g_r, g_d2, g_d3;
    logic        g_dz, g_to;
    int          g_n, g_starts, g_scyc;
    bit          g_rdy;

    task automatic test_reset();
        total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", b0.in_ready); end
        total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", b0.out_valid); end
        total++; if (b0.div_start !== 1'b0) begin bad++; $display("FAIL reset_div_start got=%0b want=0", b0.div_start); end
        total++; if (b0.div_data !== 16'd0) begin bad++; $display("FAIL reset_div_data got=%0d want=0", b0.div_data); end
        total++; if (b0.quotient !== 16'd0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", b0.quotient); end
        total++; if (b0.remainder !== 16'd0) begin bad++; $display("FAIL reset_remainder got=%0d want=0", b0.remainder); end
        total++; if (b0.dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%0b want=0", b0.dz); end
        total++; if (b0.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%0b want=0", b0.timeout); end
    endtask

    task automatic test_basic();
        stub_lat = 3;
        run_txn(16'd9832, 16'd23, 100, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_scyc !== 1) begin bad++; $display("FAIL basic_start_cycle got=%0d want=1", g_scyc); end
        total++; if (g_starts !== 1) begin bad++; $display("FAIL basic_start_count got=%0d want=1", g_starts); end
        total++; if (g_d2 !== 16'd9832) begin bad++; $display("FAIL basic_bus_dividend got=%0d want=9832", g_d2); end
        total++; if (g_d3 !== 16'd23) begin bad++; $display("FAIL basic_bus_divisor got=%0d want=23", g_d3); end
        total++; if (g_n !== 4 + 3 + 2) begin bad++; $display("FAIL basic_latency got=%0d want=9", g_n); end
        total++; if (g_q !== 16'd427) begin bad++; $display("FAIL basic_quotient got=%0d want=427", g_q); end
        total++; if (g_r !== 16'd11) begin bad++; $display("FAIL basic_remainder got=%0d want=11", g_r); end
        total++; if (g_dz !== 1'b0 || g_to !== 1'b0) begin bad++; $display("FAIL basic_flags got dz=%0b to=%0b want 0 0", g_dz, g_to); end
        total++; if (g_rdy !== 1'b0) begin bad++; $display("FAIL basic_in_ready_busy got=1 want=0"); end
    endtask

    task automatic test_edge_values();
        stub_lat = 0;
        run_txn(16'd5, 16'd7, 100, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_q !== 16'd0 || g_r !== 16'd5) begin bad++; $display("FAIL small_result got q=%0d r=%0d want q=0 r=5", g_q, g_r); end
        total++; if (g_n !== 6) begin bad++; $display("FAIL small_latency got=%0d want=6", g_n); end
        // a true repeated-subtraction divider needs 65535 steps here
        stub_lat = 65535;
        run_txn(16'd65535, 16'd1, 65600, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_q !== 16'd65535 || g_r !== 16'd0) begin bad++; $display("FAIL max_result got q=%0d r=%0d want q=65535 r=0", g_q, g_r); end
        total++; if (g_to !== 1'b0) begin bad++; $display("FAIL max_timeout got=%0b want=0", g_to); end
        total++; if (g_n !== 65535 + 6) begin bad++; $display("FAIL max_latency got=%0d want=65541", g_n); end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        int          lat;
        for (int i = 0; i < 15; i++) begin
            a   = 16'($urandom_range(0, 65535));
            b   = (i % 3 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
            lat = $urandom_range(0, 12);
            stub_lat = lat;
            run_txn(a, b, 100, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
            total++; if (g_q !== a / b || g_r !== a % b) begin bad++; $display("FAIL rand_result %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", a, b, g_q, g_r, a / b, a % b); end
            total++; if (g_dz !== 1'b0 || g_to !== 1'b0) begin bad++; $display("FAIL rand_flags got dz=%0b to=%0b want 0 0", g_dz, g_to); end
            total++; if (g_n !== lat + 6) begin bad++; $display("FAIL rand_latency got=%0d want=%0d", g_n, lat + 6); end
        end
    endtask

    task automatic test_div_zero();
        run_txn(16'd100, 16'd0, 20, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_n !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", g_n); end
        total++; if (g_starts !== 0) begin bad++; $display("FAIL dz_start_count got=%0d want=0", g_starts); end
        total++; if (g_q !== 16'hFFFF || g_r !== 16'd100) begin bad++; $display("FAIL dz_result got q=%0h r=%0d want q=ffff r=100", g_q, g_r); end
        total++; if (g_dz !== 1'b1 || g_to !== 1'b0) begin bad++; $display("FAIL dz_flags got dz=%0b to=%0b want 1 0", g_dz, g_to); end
    endtask

    task automatic t16_run(input bit raise, output int n_done, output logic [15:0] q,
                           output logic [15:0] r, output logic fdz, output logic fto);
        int n;
        bit done;
        b1.in_valid = 1'b1;
        b1.dividend = 16'd50;
        b1.divisor  = 16'd3;
        @(negedge clk);
        b1.in_valid = 1'b0;
        n = 1; done = 1'b0; n_done = -1;
        q = 16'd0; r = 16'd0; fdz = 1'b0; fto = 1'b0;
        while (!done && n < 40) begin
            if (b1.out_valid === 1'b1) begin
                done = 1'b1; n_done = n;
                q = b1.quotient; r = b1.remainder; fdz = b1.dz; fto = b1.timeout;
            end else begin
                // WAIT spans cycles 4..19; cycle 19 is its last
                if (raise && n == 19) b1.div_stop = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        b1.div_stop = 1'b0;
    endtask

    task automatic test_timeout();
        t16_run(1'b0, g_n, g_q, g_r, g_dz, g_to);
        total++; if (g_n !== 4 + 16) begin bad++; $display("FAIL to_latency got=%0d want=20", g_n); end
        total++; if (g_to !== 1'b1 || g_dz !== 1'b0) begin bad++; $display("FAIL to_flags got to=%0b dz=%0b want 1 0", g_to, g_dz); end
        total++; if (g_q !== 16'd0 || g_r !== 16'd0) begin bad++; $display("FAIL to_result got q=%0d r=%0d want 0 0", g_q, g_r); end
        @(negedge clk);
        t16_run(1'b1, g_n, g_q, g_r, g_dz, g_to);
        total++; if (g_n !== 20) begin bad++; $display("FAIL late_stop_latency got=%0d want=20", g_n); end
        total++; if (g_to !== 1'b0) begin bad++; $display("FAIL late_stop_timeout got=%0b want=0", g_to); end
        total++; if (g_q !== 16'h1111 || g_r !== 16'h2222) begin bad++; $display("FAIL late_stop_result got q=%0h r=%0h want 1111 2222", g_q, g_r); end
    endtask

    task automatic test_backpressure();
        bit held_bad, rdy_bad, start_bad, valid_bad;
        int k;
        @(negedge clk);
        b0.out_ready = 1'b0;
        stub_lat = 2;
        run_txn(16'd777, 16'd7, 50, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_q !== 16'd111 || g_r !== 16'd0) begin bad++; $display("FAIL bp_first_result got q=%0d r=%0d want 111 0", g_q, g_r); end
        held_bad = 0; rdy_bad = 0; start_bad = 0; valid_bad = 0;
        b0.in_valid = 1'b1;
        b0.dividend = 16'd1234;
        b0.divisor  = 16'd10;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b0.quotient !== 16'd111 || b0.remainder !== 16'd0 || b0.dz !== 1'b0 || b0.timeout !== 1'b0) held_bad = 1;
            if (b0.in_ready !== 1'b0) rdy_bad = 1;
            if (b0.div_start !== 1'b0) start_bad = 1;
            if (b0.out_valid !== 1'b1) valid_bad = 1;
        end
        total++; if (held_bad) begin bad++; $display("FAIL bp_outputs_held got=changed want=stable"); end
        total++; if (rdy_bad) begin bad++; $display("FAIL bp_in_ready got=1 want=0"); end
        total++; if (start_bad) begin bad++; $display("FAIL bp_div_start got=1 want=0"); end
        total++; if (valid_bad) begin bad++; $display("FAIL bp_out_valid got=0 want=1"); end
        b0.out_ready = 1'b1;
        @(negedge clk);
        total++; if (b0.in_ready !== 1'b1 || b0.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got in_ready=%0b out_valid=%0b want 1 0", b0.in_ready, b0.out_valid); end
        @(negedge clk);
        b0.in_valid = 1'b0;
        total++; if (b0.div_start !== 1'b1) begin bad++; $display("FAIL bp_next_start got=%0b want=1", b0.div_start); end
        k = 0;
        while (b0.out_valid !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        total++; if (b0.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_done got out_valid=%0b want=1", b0.out_valid); end
        total++; if (b0.quotient !== 16'd123 || b0.remainder !== 16'd4) begin bad++; $display("FAIL bp_next_result got q=%0d r=%0d want 123 4", b0.quotient, b0.remainder); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        // divider keeps its stale stop level and ignores this run
        stub_hold   = 1'b1;
        b0.in_valid = 1'b1;
        b0.dividend = 16'd4000;
        b0.divisor  = 16'd9;
        @(negedge clk);
        b0.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%0b want=0", b0.out_valid); end
        total++; if (b0.quotient !== 16'd0 || b0.remainder !== 16'd0) begin bad++; $display("FAIL rmid_result got q=%0d r=%0d want 0 0", b0.quotient, b0.remainder); end
        total++; if (b0.dz !== 1'b0 || b0.timeout !== 1'b0) begin bad++; $display("FAIL rmid_flags got dz=%0b to=%0b want 0 0", b0.dz, b0.timeout); end
        total++; if (b0.div_start !== 1'b0 || b0.div_data !== 16'd0) begin bad++; $display("FAIL rmid_bus got start=%0b data=%0d want 0 0", b0.div_start, b0.div_data); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        total++; if (b0.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%0b want=1", b0.in_ready); end
        repeat (3) @(negedge clk);
        total++; if (b0.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_stop got out_valid=%0b want=0", b0.out_valid); end
        stub_hold = 1'b0;
        stub_lat  = 4;
        run_txn(16'd4000, 16'd9, 60, g_q, g_r, g_dz, g_to, g_n, g_starts, g_scyc, g_d2, g_d3, g_rdy);
        total++; if (g_q !== 16'd444 || g_r !== 16'd4) begin bad++; $display("FAIL rmid_next_result got q=%0d r=%0d want 444 4", g_q, g_r); end
        total++; if (g_n !== 4 + 6) begin bad++; $display("FAIL rmid_next_latency got=%0d want=10", g_n); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n        = 1'b0;
        b0.in_valid  = 1'b0;
        b0.dividend  = 16'd0;
        b0.divisor   = 16'd0;
        b0.out_ready = 1'b1;
        b1.in_valid  = 1'b0;
        b1.dividend  = 16'd0;
        b1.divisor   = 16'd0;
        b1.out_ready = 1'b1;
        b1.div_stop  = 1'b0;
        b1.div_q     = 16'h1111;
        b1.div_rem   = 16'h2222;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_edge_values();
        test_random();
        test_div_zero();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
